brnch_pred_corr_param: RTL
==========================

# brnch_pred_corr_param

Parametrised branch predictor and flush controller for the 5-stage MIPS pipeline. It generalises the 2-bit correlating handler. The prediction table depth, counter width and history length are parameters, and the predictor mode is selectable: static not-taken, bimodal or gshare. It predicts `beq` in IF and tracks the prediction into ID. When the branch resolves in ID, it raises flush on a misprediction, updates the counter, repairs speculative global history and keeps performance counters.

## Interface
- `IDX_W`, 5, table index width; table holds 2^IDX_W counters
- `HIST_W`, 4, global history length; 1 ≤ HIST_W ≤ IDX_W
- `CNT_W`, 2, saturating counter width; ≥ 2
- `MODE`, 2, predictor mode: 0 static-NT, 1 bimodal (PC only), 2 gshare (PC XOR history)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `stall`  in  1  branch hazard stall from the hazard unit; freezes all state
- `if_br`  in  1  IF instruction is a branch (opcode 000100)
- `if_pc_lo`  in  IDX_W  low PC word-address bits of the IF instruction
- `id_taken`  in  1  actual branch outcome in ID (forwarded rs == rt)
- `pred_taken`  out  1  prediction for the IF branch
- `flush`  out  1  ID misprediction; flush the IF/ID register and redirect the PC
- `ghr`  out  HIST_W  current speculative global history
- `br_cnt`  out  16  resolved-branch count, saturating
- `mispred_cnt`  out  16  misprediction count, saturating

## Operation
- **Table:** 2^IDX_W counters, each CNT_W bits. Every counter resets to weakly-not-taken, 2^(CNT_W-1)-1.
- **Index:**
  - MODE 1: `if_pc_lo`.
  - MODE 2: `if_pc_lo` XOR history zero-extended to IDX_W.
  - MODE 0: table is ignored.
- **Prediction:** `raw` = MSB of the indexed counter; 0 in MODE 0.
  - `pred_taken = if_br & raw & !stall & !flush`.
- **ID pipeline register** (fields `vld`, `idx`, `pred`, `snap`):
  - Loads when `!stall`.
  - `vld <= if_br & !flush`, `idx <= index`, `pred <= raw`, `snap <=` GHR before this cycle's shift.
  - Holds while `stall=1`.
- **Resolve condition:** `res = vld & !stall`.
  - `flush = res & (id_taken != pred)`, combinational.
- **Counter update (when `res`):** at `idx`, increment if `id_taken`, otherwise decrement; saturate at 2^CNT_W-1 and 0.
  - Skipped in MODE 0.
- **GHR (shift-left, new bit at LSB), priority order:**
  1. `stall`: hold.
  2. `flush`: `ghr <= {snap[HIST_W-2:0], id_taken}` (for HIST_W=1: `id_taken`). The IF branch is discarded, so no speculative shift.
  3. `if_br`: `ghr <= {ghr[HIST_W-2:0], raw}`.
  4. Otherwise: hold.
  - In MODE 0 and MODE 1, the GHR is still maintained but not used for indexing.
- **Same-index read and update in one cycle:** IF reads the pre-update value; there is no bypass.
- **Counters:** `br_cnt` increments on `res`; `mispred_cnt` increments on `flush`. Both stop at 0xFFFF.
- **Reset:**
  - All table entries weakly-not-taken; `ghr`, `vld`, `pred`, `snap`, `br_cnt`, `mispred_cnt` = 0.
  - Outputs `pred_taken=0`, `flush=0`.
  - Reset mid-operation discards any in-flight branch and raises no flush.

## Timing
- `pred_taken` is combinational in the same cycle as `if_br` and `if_pc_lo`.
- A branch predicted in cycle N resolves in cycle N+1, or in the first cycle after `stall` drops.
- `flush` is combinational in the resolve cycle.
- Counter and GHR updates are visible from the next cycle.
- A stall of any length delays resolution but never duplicates it. `br_cnt` increments exactly once per branch.
- Back-to-back branches: predicted in N and N+1, resolved in N+1 and N+2. If the first mispredicts, the second is cancelled (`vld=0`) and never resolves.

## Test plan
- **Reset:** hold `rst_n=0` 2 cycles with `if_br=1` → `pred_taken=0`, `flush=0`, `ghr=0`, both counters 0; first resolve after reset uses fresh state.
- **Bimodal training** (MODE=1, CNT_W=2): branch at `if_pc_lo=3` taken 3 times, one cycle apart.
  - 1st: `pred_taken=0`, `flush=1`.
  - 2nd and 3rd: `pred_taken=1`, `flush=0`.
  - Result: `br_cnt=3`, `mispred_cnt=1`.
  - Entry 3 saturates at 3 after a 4th taken; one not-taken then gives pred still 1.
- **Gshare alternating** (MODE=2, HIST_W=4): single branch at `if_pc_lo=5` alternating T/N for 40 occurrences.
  - After warm-up, mispredictions stop.
  - Last 16 resolves: `mispred_cnt` unchanged.
- **Mispredict with back-to-back branch:** branch A predicted NT with `ghr=4'b0110`, branch B in IF during A's resolve, A actually taken.
  - `flush=1`; B gets `pred_taken=0` and is not counted.
  - Next cycle `ghr=4'b1101`.
- **Stall hold:** branch in ID, `stall=1` for 3 cycles.
  - `flush=0`, `pred_taken=0`; `ghr`, table and `br_cnt` unchanged.
  - On release, exactly one resolve and `br_cnt` increments by 1.
- **MODE=0 and saturation:** 70000 taken branches.
  - `pred_taken` always 0.
  - `br_cnt` and `mispred_cnt` stick at 0xFFFF.

Source files
------------

// File: rtl/brnch_pred_corr_param.sv
// Purpose: parametrised beq predictor (static-NT / bimodal / gshare) with ID-stage flush and perf counters.
// Latency: pred_taken combinational in IF; resolves one cycle later in ID, flush combinational there.
// Backpressure: stall freezes every register and masks prediction, resolution and flush.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   stall              hazard-unit stall, holds all state
//   if_br, if_pc_lo    IF branch flag and low word-address PC bits (table index source)
//   id_taken           resolved outcome of the branch sitting in ID
//   pred_taken         prediction for the IF branch
//   flush              ID misprediction: kill IF/ID and redirect the PC
//   ghr                speculative global history (newest outcome at LSB)
//   br_cnt             resolved branches, saturating at 0xFFFF
//   mispred_cnt        mispredictions, saturating at 0xFFFF
module brnch_pred_corr_param #(
  parameter int IDX_W  = 5,
  parameter int HIST_W = 4,
  parameter int CNT_W  = 2,
  parameter int MODE   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              if_br,
  input  logic [IDX_W-1:0]  if_pc_lo,
  input  logic              id_taken,
  output logic              pred_taken,
  output logic              flush,
  output logic [HIST_W-1:0] ghr,
  output logic [15:0]       br_cnt,
  output logic [15:0]       mispred_cnt
);

  localparam int TBL_N = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]  tbl [TBL_N];

  // ID-stage copy of the branch fetched last cycle
  logic              id_vld;
  logic [IDX_W-1:0]  id_idx;
  logic              id_pred;
  logic [HIST_W-1:0] id_snap;

  logic [IDX_W-1:0]  hist_ext;
  logic [IDX_W-1:0]  index;
  logic              raw;
  logic              res;
  logic [HIST_W-1:0] ghr_repair;
  logic [HIST_W-1:0] ghr_spec;

  assign hist_ext = IDX_W'(ghr);

  always_comb begin
    index = if_pc_lo;
    if (MODE == 2) index = if_pc_lo ^ hist_ext;
  end

  assign raw = (MODE == 0) ? 1'b0 : tbl[index][CNT_W-1];

  // rst_n gating keeps both outputs quiet during reset, including an in-flight branch
  assign res        = id_vld & ~stall;
  assign flush      = rst_n & res & (id_taken != id_pred);
  assign pred_taken = rst_n & if_br & raw & ~stall & ~flush;

  // Repair restarts from the history seen when the branch was predicted,
  // so the wrong-path speculative bit is dropped.
  generate
    if (HIST_W == 1) begin : g_hist1
      assign ghr_repair = id_taken;
      assign ghr_spec   = raw;
    end else begin : g_histn
      assign ghr_repair = {id_snap[HIST_W-2:0], id_taken};
      assign ghr_spec   = {ghr[HIST_W-2:0], raw};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr         <= '0;
      id_vld      <= 1'b0;
      id_idx      <= '0;
      id_pred     <= 1'b0;
      id_snap     <= '0;
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (!stall) begin
      id_vld  <= if_br & ~flush;
      id_idx  <= index;
      id_pred <= raw;
      id_snap <= ghr;

      if (flush)      ghr <= ghr_repair;
      else if (if_br) ghr <= ghr_spec;

      if (res && br_cnt != 16'hFFFF)        br_cnt      <= br_cnt + 16'd1;
      if (flush && mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
    end
  end

  // Table write uses the ID index; an IF read of the same entry this cycle
  // sees the old value (no bypass).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_N; i++) tbl[i] <= CNT_INIT;
    end else if (res && MODE != 0) begin
      if (id_taken) begin
        if (tbl[id_idx] != CNT_MAX) tbl[id_idx] <= tbl[id_idx] + CNT_ONE;
      end else begin
        if (tbl[id_idx] != '0) tbl[id_idx] <= tbl[id_idx] - CNT_ONE;
      end
    end
  end

endmodule
